// File: rtl/div_unit_pkg.sv
// Shared encodings and helpers for the multi-cycle divider.
// Imported by the divider interface consumers and the divider itself.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic RstEnable         = 1'b1;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [5:0] DivSteps = 6'd32;

   // Magnitude of an operand; unsigned operands pass through untouched.
   function automatic logic [31:0] mag32(input logic sd, input logic [31:0] x);
      if (sd && x[31]) begin
         return ~x + 32'd1;
      end
      return x;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between EX and the divider.
// EX drives the request side, the divider drives the result side.
interface div_unit_if;

   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output start_i,
      output annul_i,
      input  result_o,
      input  ready_o
   );

   modport slave (
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  start_i,
      input  annul_i,
      output result_o,
      output ready_o
   );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}, held while EX keeps start_i high.
module div_unit
   import div_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);

   div_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] dvsr_q;
   logic        negq_q;
   logic        negr_q;
   logic [63:0] result_q;
   logic        ready_q;

   logic [32:0] top_d;
   logic [32:0] trial_d;
   logic [63:0] acc_d;
   logic [31:0] quo_d;
   logic [31:0] rem_d;
   logic        accept_d;

   // acc_q holds {partial remainder, dividend/quotient bits}.
   always_comb begin
      top_d    = acc_q[63:31];
      trial_d  = top_d - {1'b0, dvsr_q};
      acc_d    = trial_d[32] ? {acc_q[62:0], 1'b0}
                             : {trial_d[31:0], acc_q[30:0], 1'b1};
      quo_d    = negq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem_d    = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      accept_d = (bus.start_i == DivStart) && !bus.annul_i;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         acc_q    <= '0;
         dvsr_q   <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
      end else begin
         unique case (state_q)
            DivFree: begin
               result_q <= '0;
               ready_q  <= DivResultNotReady;
               if (accept_d) begin
                  cnt_q  <= '0;
                  acc_q  <= {32'd0, mag32(bus.signed_div_i, bus.opdata1_i)};
                  dvsr_q <= mag32(bus.signed_div_i, bus.opdata2_i);
                  negq_q <= bus.signed_div_i
                          & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                  negr_q <= bus.signed_div_i & bus.opdata1_i[31];
                  if (bus.opdata2_i == 32'd0) begin
                     state_q <= DivByZero;
                  end else begin
                     state_q <= DivOn;
                  end
               end
            end
            DivByZero: begin
               if (bus.annul_i) begin
                  state_q <= DivFree;
               end else begin
                  state_q  <= DivEnd;
                  result_q <= '0;
                  ready_q  <= DivResultReady;
               end
            end
            DivOn: begin
               if (bus.annul_i) begin
                  state_q <= DivFree;
                  cnt_q   <= '0;
               end else if (cnt_q != DivSteps) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 6'd1;
               end else begin
                  // Final cycle: sign fixup straight into the output register.
                  state_q  <= DivEnd;
                  cnt_q    <= '0;
                  result_q <= {rem_d, quo_d};
                  ready_q  <= DivResultReady;
               end
            end
            DivEnd: begin
               if (bus.start_i == DivStop) begin
                  state_q  <= DivFree;
                  result_q <= '0;
                  ready_q  <= DivResultNotReady;
               end
            end
         endcase
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed checks of div_unit against a plain-arithmetic model.
// Covers latency, hold/drop handshake, annul, reset mid-operation.
module tb_div_unit;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   div_unit_if bus();

   div_unit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic sd,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return 64'd0;
      if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, measure latency, check hold, drop start, check clear.
   task automatic run_op(input logic sd, input logic [31:0] a,
                         input logic [31:0] b);
      logic [63:0] exp;
      int          lat;
      int          explat;
      logic        got;
      exp    = model(sd, a, b);
      explat = (b == 32'd0) ? 2 : 34;
      bus.signed_div_i = sd;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 60) begin
         step();
         lat++;
         if (lat == 1) begin
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = ~sd;
         end
         if (bus.ready_o) got = 1'b1;
      end
      check("latency", 64'(lat), 64'(explat));
      check("result", bus.result_o, exp);
      step();
      check("hold_rdy", 64'(bus.ready_o), 64'd1);
      check("hold_res", bus.result_o, exp);
      bus.start_i = 1'b0;
      step();
      check("drop_rdy", 64'(bus.ready_o), 64'd0);
      check("drop_res", bus.result_o, 64'd0);
   endtask

   initial begin
      logic        seen;
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      repeat (3) step();
      check("rst_rdy", 64'(bus.ready_o), 64'd0);
      check("rst_res", bus.result_o, 64'd0);
      rst = 1'b0;

      // First start right after reset release
      run_op(1'b0, 32'd100, 32'd7);
      check("u100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
      run_op(1'b0, 32'h1234_5678, 32'd0);
      run_op(1'b1, 32'h8000_0000, 32'd0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Annul in DivOn at N+10, restart at N+12
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         step();
         seen |= bus.ready_o;
      end
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      step();
      seen |= bus.ready_o;
      bus.annul_i = 1'b0;
      step();
      seen |= bus.ready_o;
      check("annul_no_rdy", 64'(seen), 64'd0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1);

      // Annul in DivFree blocks acceptance for 3 cycles
      bus.start_i = 1'b1;
      bus.annul_i = 1'b1;
      bus.opdata1_i = 32'd9;
      bus.opdata2_i = 32'd0;
      repeat (3) step();
      check("annul_free_rdy", 64'(bus.ready_o), 64'd0);
      bus.annul_i = 1'b0;
      run_op(1'b0, 32'd50, 32'd5);

      // Reset in the middle of DivOn
      bus.signed_div_i = 1'b1;
      bus.opdata1_i    = 32'hDEAD_BEEF;
      bus.opdata2_i    = 32'd17;
      bus.start_i      = 1'b1;
      repeat (20) step();
      rst = 1'b1;
      bus.start_i = 1'b0;
      step();
      check("midrst_rdy", 64'(bus.ready_o), 64'd0);
      check("midrst_res", bus.result_o, 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         step();
         seen |= bus.ready_o;
      end
      check("midrst_quiet", 64'(seen), 64'd0);
      run_op(1'b1, 32'hFFFF_FF00, 32'd3);

      for (int i = 0; i < 40; i++) begin
         sd = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: a = 32'h8000_0000;
            3: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(sd, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high (`RstEnable = 1'b1`).
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend; sampled with start_i.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor; sampled with start_i.
REQ-006 SHALL have port start_i, input, 1 bit: request from EX; held high by EX until ready_o is seen.
REQ-007 SHALL have port annul_i, input, 1 bit: cancel the operation in flight (flush/exception).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder, quotient}; EX maps [63:32] to hi_o and [31:0] to lo_o.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid.

Function
REQ-010 SHALL implement four states: DivFree, DivByZero, DivOn, DivEnd.
REQ-011 DivFree: start_i=1 and annul_i=0 SHALL latch operands and signed_div_i; divisor==0 goes to DivByZero, else DivOn with iteration counter=0.
REQ-012 In signed mode, negative operands SHALL be converted to two's-complement magnitude at latch time.
REQ-013 DivOn SHALL perform one restoring-division step per cycle (64-bit shift register, 33-bit trial subtract) for 32 cycles, counter 0..31.
REQ-014 When counter==32, one extra DivOn cycle SHALL apply sign fixup, then go to DivEnd.
REQ-015 Sign fixup, signed mode: quotient negated if operand signs differ; remainder takes the dividend's sign. Unsigned mode: no fixup.
REQ-016 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-017 DivByZero SHALL go to DivEnd after one cycle with result 64'h0.
REQ-018 Latency: with start_i sampled in cycle N, ready_o SHALL first be high in cycle N+34 for a nonzero divisor and N+2 for a zero divisor.
REQ-019 DivEnd SHALL drive ready_o=1 and a stable result_o while start_i=1; start_i=0 SHALL go to DivFree, with ready_o=0 and result_o=0 in the following cycle.
REQ-020 annul_i=1 in DivOn or DivByZero SHALL go to DivFree next cycle; ready_o SHALL never assert for that operation.
REQ-021 annul_i=1 in DivFree SHALL block acceptance of start_i.
REQ-022 Operand changes on opdata1_i/opdata2_i after acceptance SHALL have no effect.
REQ-023 result_o and ready_o SHALL be registered outputs; outside DivEnd, result_o=0 and ready_o=0.
REQ-024 A new start_i SHALL be accepted only in DivFree; back-to-back operations are therefore separated by at least one DivFree cycle.

Reset
REQ-025 rst=1 at any edge, including mid-DivOn, SHALL force DivFree, counter=0, internal registers=0, result_o=64'h0, ready_o=0.
REQ-026 The first start_i SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-027 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady and DivStart/DivStop SHALL be added to defines.v.
REQ-028 The block SHALL be a single module with no sub-module; the trial subtract is inline logic.
REQ-029 EX SHALL gain DIV/DIVU aluop decode, stall request and hilo write from result_o; these changes are outside this block.

Verification
REQ-030 Unsigned 100 / 7, start in cycle N -> ready_o in N+34, result_o = {32'd2, 32'd14}.
REQ-031 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
REQ-032 Divisor 0, start in cycle N -> ready_o in N+2, result 64'h0; start_i dropped -> DivFree, ready_o=0 the following cycle.
REQ-033 annul_i pulsed in cycle N+10 -> ready_o never asserts; a new start at N+12 (0xFFFFFFFF / 1 unsigned) -> {0, 0xFFFFFFFF} at N+46.
REQ-034 rst asserted in cycle N+20 -> all outputs 0 next cycle; operands changed during DivOn -> result unaffected.
